audio_mixer: RTL and testbench

AUDIO_MIXER -- requirements
Module: audio_mixer

---
 rtl/audio_mixer.sv | 125 ++++++++++++
 tb/tb_audio_mixer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/audio_mixer.sv
// Three-stage stereo audio mixer: capture sources, apply per-source gain,
// then sum, saturate and scale by a soft-mute ramp shared by both channels.
module audio_mixer #(
  parameter logic [15:0] SPK_LEVEL = 16'h2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_stb_i,
  input  logic [15:0] ssp_audio_i,
  input  logic [9:0]  mb_audio_l_i,
  input  logic [9:0]  mb_audio_r_i,
  input  logic        speaker_i,
  input  logic [1:0]  ssp_gain_i,
  input  logic [1:0]  mb_gain_i,
  input  logic [1:0]  spk_gain_i,
  input  logic        mute_i,
  output logic [15:0] audio_l_o,
  output logic [15:0] audio_r_o,
  output logic        valid_o,
  output logic        clip_o,
  output logic        muted_o
);

  localparam logic [4:0] RAMP_MAX = 5'd16;

  function automatic logic [15:0] f_gain(input logic [15:0] v, input logic [1:0] g);
    case (g)
      2'd3:    f_gain = v;
      2'd2:    f_gain = v >> 1;
      2'd1:    f_gain = v >> 2;
      default: f_gain = 16'h0000;
    endcase
  endfunction

  logic [4:0]  r_ramp;
  logic        r_s1_valid, r_s2_valid, r_valid, r_clip;
  logic [15:0] r_s1_ssp, r_s1_spk, r_s2_ssp, r_s2_spk;
  logic [1:0]  r_s1_ssp_gain, r_s1_mb_gain, r_s1_spk_gain;
  logic [4:0]  r_s1_ramp, r_s2_ramp;
  logic [9:0]  w_mb_in [2];
  logic [15:0] r_s1_mb [2];
  logic [15:0] r_s2_mb [2];
  logic [15:0] w_out   [2];
  logic [1:0]  w_clip;
  logic [15:0] r_audio [2];

  assign w_mb_in[0] = mb_audio_l_i;
  assign w_mb_in[1] = mb_audio_r_i;

  // Ramp moves one step per strobe and saturates at both ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ramp <= 5'd0;
    end else if (sample_stb_i) begin
      if (mute_i && r_ramp != 5'd0)
        r_ramp <= r_ramp - 5'd1;
      else if (!mute_i && r_ramp < RAMP_MAX)
        r_ramp <= r_ramp + 5'd1;
    end
  end

  // Stage valid bits; data registers below need no reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_valid    <= 1'b0;
      r_clip     <= 1'b0;
    end else begin
      r_s1_valid <= sample_stb_i;
      r_s2_valid <= r_s1_valid;
      r_valid    <= r_s2_valid;
      r_clip     <= r_s2_valid & (|w_clip);
    end
  end

  always_ff @(posedge clk) begin
    if (sample_stb_i) begin
      r_s1_ssp      <= ssp_audio_i;
      r_s1_spk      <= speaker_i ? SPK_LEVEL : 16'h0000;
      r_s1_ssp_gain <= ssp_gain_i;
      r_s1_mb_gain  <= mb_gain_i;
      r_s1_spk_gain <= spk_gain_i;
      r_s1_ramp     <= r_ramp;
    end
    if (r_s1_valid) begin
      r_s2_ssp  <= f_gain(r_s1_ssp, r_s1_ssp_gain);
      r_s2_spk  <= f_gain(r_s1_spk, r_s1_spk_gain);
      r_s2_ramp <= r_s1_ramp;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic [17:0] w_sum;
      logic [15:0] w_sat;
      logic [20:0] w_prod;

      assign w_sum      = {2'b00, r_s2_ssp} + {2'b00, r_s2_mb[gi]} + {2'b00, r_s2_spk};
      assign w_clip[gi] = |w_sum[17:16];
      assign w_sat      = w_clip[gi] ? 16'hFFFF : w_sum[15:0];
      assign w_prod     = {5'b0, w_sat} * {16'b0, r_s2_ramp};
      assign w_out[gi]  = 16'(w_prod >> 4);

      always_ff @(posedge clk) begin
        if (sample_stb_i)
          r_s1_mb[gi] <= {1'b0, w_mb_in[gi], 5'b00000};
        if (r_s1_valid)
          r_s2_mb[gi] <= f_gain(r_s1_mb[gi], r_s1_mb_gain);
        if (reset)
          r_audio[gi] <= 16'h0000;
        else if (r_s2_valid)
          r_audio[gi] <= w_out[gi];
      end
    end
  endgenerate

  assign audio_l_o = r_audio[0];
  assign audio_r_o = r_audio[1];
  assign valid_o   = r_valid;
  assign clip_o    = r_clip;
  assign muted_o   = (r_ramp == 5'd0);

endmodule

// File: tb/tb_audio_mixer.sv
// Directed bench for audio_mixer: fade-in, latency, gains, saturation,
// soft mute and reset flush, all against hand-computed values.
module tb_audio_mixer;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_stb_i;
  logic [15:0] ssp_audio_i;
  logic [9:0]  mb_audio_l_i, mb_audio_r_i;
  logic        speaker_i;
  logic [1:0]  ssp_gain_i, mb_gain_i, spk_gain_i;
  logic        mute_i;
  logic [15:0] audio_l_o, audio_r_o;
  logic        valid_o, clip_o, muted_o;

  int n_checks = 0;
  int n_pass   = 0;

  audio_mixer dut (
    .clk          (clk),
    .reset        (reset),
    .sample_stb_i (sample_stb_i),
    .ssp_audio_i  (ssp_audio_i),
    .mb_audio_l_i (mb_audio_l_i),
    .mb_audio_r_i (mb_audio_r_i),
    .speaker_i    (speaker_i),
    .ssp_gain_i   (ssp_gain_i),
    .mb_gain_i    (mb_gain_i),
    .spk_gain_i   (spk_gain_i),
    .mute_i       (mute_i),
    .audio_l_o    (audio_l_o),
    .audio_r_o    (audio_r_o),
    .valid_o      (valid_o),
    .clip_o       (clip_o),
    .muted_o      (muted_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ramp-scaled value of the standard 0x5000 mix.
  function automatic logic [15:0] scaled(input int r);
    return 16'(32'h500 * r);
  endfunction

  // One isolated strobe with current inputs; checks latency and results.
  task automatic send(input string tag, input logic [15:0] el, input logic [15:0] er,
                      input logic ec);
    sample_stb_i = 1'b1;
    tick();
    sample_stb_i = 1'b0;
    chk({tag, ".v1"}, valid_o, 1'b0);
    tick();
    chk({tag, ".v2"}, valid_o, 1'b0);
    tick();
    chk({tag, ".v3"}, valid_o, 1'b1);
    chk({tag, ".l"}, audio_l_o, el);
    chk({tag, ".r"}, audio_r_o, er);
    chk({tag, ".clip"}, clip_o, ec);
    $display("txn %s l=%h r=%h clip=%b muted=%b", tag, audio_l_o, audio_r_o, clip_o, muted_o);
  endtask

  task automatic std_inputs();
    ssp_audio_i  = 16'h1000;
    mb_audio_l_i = 10'h100;
    mb_audio_r_i = 10'h100;
    speaker_i    = 1'b1;
    ssp_gain_i   = 2'd3;
    mb_gain_i    = 2'd3;
    spk_gain_i   = 2'd3;
  endtask

  initial begin
    logic [15:0] seq_ssp [4];
    reset = 1'b1;
    sample_stb_i = 1'b0;
    mute_i = 1'b0;
    std_inputs();
    repeat (3) tick();
    chk("rst.l", audio_l_o, 16'h0);
    chk("rst.r", audio_r_o, 16'h0);
    chk("rst.valid", valid_o, 1'b0);
    chk("rst.clip", clip_o, 1'b0);
    chk("rst.muted", muted_o, 1'b1);
    reset = 1'b0;
    tick();
    chk("fade.muted0", muted_o, 1'b1);

    // Fade-in: strobes 1..16 use ramp 0..15, strobe 17 onwards full scale.
    for (int k = 1; k <= 18; k++) begin
      send($sformatf("fade%0d", k), scaled(k > 16 ? 16 : k - 1), scaled(k > 16 ? 16 : k - 1), 1'b0);
      if (k == 1) chk("fade.muted1", muted_o, 1'b0);
    end
    tick();
    chk("hold.valid", valid_o, 1'b0);
    chk("hold.l", audio_l_o, 16'h5000);

    // Back-to-back strobes: valid at N+3..N+6 with per-sample data.
    mb_audio_l_i = 10'h0; mb_audio_r_i = 10'h0; speaker_i = 1'b0;
    seq_ssp[0] = 16'h1000; seq_ssp[1] = 16'h2000; seq_ssp[2] = 16'h3000; seq_ssp[3] = 16'h4000;
    for (int t = 0; t < 8; t++) begin
      sample_stb_i = (t < 4);
      if (t < 4) ssp_audio_i = seq_ssp[t];
      tick();
      chk($sformatf("b2b.v%0d", t + 1), valid_o, (t + 1 >= 3 && t + 1 <= 6));
      if (t + 1 >= 3 && t + 1 <= 6) begin
        chk($sformatf("b2b.l%0d", t + 1), audio_l_o, seq_ssp[t - 2]);
        $display("txn b2b%0d l=%h r=%h", t - 2, audio_l_o, audio_r_o);
      end
    end
    sample_stb_i = 1'b0;

    // Gains at ramp 16.
    ssp_audio_i = 16'h8000;
    ssp_gain_i = 2'd2; send("gain2", 16'h4000, 16'h4000, 1'b0);
    ssp_gain_i = 2'd1; send("gain1", 16'h2000, 16'h2000, 1'b0);
    ssp_gain_i = 2'd0; send("gain0", 16'h0000, 16'h0000, 1'b0);
    ssp_audio_i = 16'h0; mb_audio_l_i = 10'h100; mb_audio_r_i = 10'h200;
    speaker_i = 1'b1; mb_gain_i = 2'd1; spk_gain_i = 2'd2;
    send("gain_mbspk", 16'h1800, 16'h2000, 1'b0);

    // Saturation and the exact-full-scale boundary.
    ssp_gain_i = 2'd3; mb_gain_i = 2'd3; spk_gain_i = 2'd3; speaker_i = 1'b0;
    ssp_audio_i = 16'hFFFF; mb_audio_l_i = 10'h3FF; mb_audio_r_i = 10'h0;
    send("sat", 16'hFFFF, 16'hFFFF, 1'b1);
    mb_audio_l_i = 10'h0;
    send("sat_edge", 16'hFFFF, 16'hFFFF, 1'b0);
    ssp_audio_i = 16'h7000;
    send("nosat", 16'h7000, 16'h7000, 1'b0);

    // Soft mute down to zero, then reversal mid-ramp.
    std_inputs();
    mute_i = 1'b1;
    for (int k = 1; k <= 17; k++) send($sformatf("mute%0d", k), scaled(17 - k), scaled(17 - k), 1'b0);
    chk("mute.muted", muted_o, 1'b1);
    mute_i = 1'b0;
    for (int k = 0; k < 8; k++) send($sformatf("up%0d", k), scaled(k), scaled(k), 1'b0);
    mute_i = 1'b1;
    for (int k = 8; k > 4; k--) send($sformatf("down%0d", k), scaled(k), scaled(k), 1'b0);
    mute_i = 1'b0;
    for (int k = 4; k < 7; k++) send($sformatf("rev%0d", k), scaled(k), scaled(k), 1'b0);
    chk("rev.muted", muted_o, 1'b0);

    // Reset one cycle after a strobe flushes the pipeline.
    sample_stb_i = 1'b1;
    tick();
    sample_stb_i = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int t = 2; t <= 6; t++) begin
      tick();
      chk($sformatf("flush.v%0d", t), valid_o, 1'b0);
    end
    chk("flush.l", audio_l_o, 16'h0);
    chk("flush.r", audio_r_o, 16'h0);
    chk("flush.muted", muted_o, 1'b1);
    $display("txn flush l=%h r=%h muted=%b", audio_l_o, audio_r_o, muted_o);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
